// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bring-up bus master: I/O addresses,
// FSM states and the baud divisor calculation.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        POLL_RX,
        READ,
        POLL_TX,
        WRITE,
        GAP
    } state_e;

    function automatic logic [15:0] baud_div(input int unsigned clk_freq,
                                             input logic [1:0]  br_cfg);
        int unsigned baud;
        case (br_cfg)
            2'b00:   baud = 4800;
            2'b01:   baud = 9600;
            2'b10:   baud = 19200;
            default: baud = 38400;
        endcase
        return 16'(clk_freq / (16 * baud));
    endfunction

endpackage

// File: rtl/spart_bus_if.sv
// Data-side bus interface: registered tri-state write driver and the
// read-capture register that holds the most recently received byte.
module spart_bus_if (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       drive_i,
    input  logic [7:0] wdata_i,
    input  logic       capture_i,
    inout  wire  [7:0] databus_io,
    output logic [7:0] rx_byte_o
);

    logic       drive_q;
    logic [7:0] wdata_q;
    logic [7:0] rx_q;

    // Enable comes straight from a flop with async clear, so reset drops the bus without a glitch.
    assign databus_io = drive_q ? wdata_q : 'z;
    assign rx_byte_o  = rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drive_q <= 1'b0;
            wdata_q <= '0;
            rx_q    <= '0;
        end else begin
            drive_q <= drive_i;
            wdata_q <= wdata_i;
            if (capture_i) begin
                rx_q <= databus_io;
            end
        end
    end

endmodule

// File: rtl/spart_driver.sv
// Bring-up bus master for the SPART: programs the baud divisor from br_cfg,
// then echoes every received byte back to the transmitter.
module spart_driver
    import spart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  br_cfg,
    input  logic        rda,
    input  logic        tbr,
    output logic        iocs,
    output logic        iorw,
    output logic [1:0]  ioaddr,
    inout  wire  [7:0]  databus,
    output logic [7:0]  last_byte,
    output logic [15:0] echo_cnt
);

    state_e      state_q, state_d;
    logic [1:0]  cfg_q, prog_cfg_q;
    logic        pending_q, pending_d;
    logic        iocs_q, iorw_q;
    logic [1:0]  ioaddr_q;
    logic [15:0] echo_cnt_q;
    logic        acc_cs, acc_rw;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_wdata;
    logic [15:0] div;
    logic        cfg_diff;

    // Bus signals are registered from the current state, so each access appears the cycle after its state.
    always_comb begin
        state_d   = state_q;
        acc_cs    = 1'b0;
        acc_rw    = 1'b1;
        acc_addr  = ADDR_BUF;
        acc_wdata = '0;
        div       = baud_div(CLK_FREQ, (state_q == INIT_LO) ? br_cfg : prog_cfg_q);
        case (state_q)
            INIT_LO: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_addr  = ADDR_DBL;
                acc_wdata = div[7:0];
                state_d   = INIT_HI;
            end
            INIT_HI: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_addr  = ADDR_DBH;
                acc_wdata = div[15:8];
                state_d   = POLL_RX;
            end
            POLL_RX: begin
                if (rda)            state_d = READ;
                else if (pending_q) state_d = INIT_LO;
            end
            READ: begin
                acc_cs  = 1'b1;
                state_d = POLL_TX;
            end
            POLL_TX: begin
                if (tbr) state_d = WRITE;
            end
            WRITE: begin
                acc_cs    = 1'b1;
                acc_rw    = 1'b0;
                acc_wdata = last_byte;
                state_d   = GAP;
            end
            GAP:     state_d = POLL_RX;
            default: state_d = INIT_LO;
        endcase
        cfg_diff  = (state_q != INIT_LO) && (cfg_q != prog_cfg_q);
        pending_d = (state_d == INIT_LO) ? 1'b0 : (pending_q | cfg_diff);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT_LO;
            cfg_q      <= '0;
            prog_cfg_q <= '0;
            pending_q  <= 1'b0;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= ADDR_BUF;
            echo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= br_cfg;
            pending_q <= pending_d;
            iocs_q    <= acc_cs;
            iorw_q    <= acc_rw;
            ioaddr_q  <= acc_addr;
            if (state_q == INIT_LO) prog_cfg_q <= br_cfg;
            if (state_q == WRITE)   echo_cnt_q <= echo_cnt_q + 16'd1;
        end
    end

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign echo_cnt = echo_cnt_q;

    spart_bus_if u_bus (
        .clk        (clk),
        .rst_n      (rst),
        .drive_i    (acc_cs & ~acc_rw),
        .wdata_i    (acc_wdata),
        .capture_i  (iocs_q & iorw_q),
        .databus_io (databus),
        .rx_byte_o  (last_byte)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver with a bus-transaction scoreboard.
module tb_spart_driver;

    localparam logic [7:0] IDLE_PAT = 8'hC3;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst, rda, tbr;
    logic [1:0]  br_cfg;
    logic [7:0]  rx_byte;
    logic        iocs, iorw;
    logic [1:0]  ioaddr;
    wire  [7:0]  databus;
    logic [7:0]  last_byte;
    logic [15:0] echo_cnt;
    logic [15:0] exp_cnt;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // SPART model: returns rx_byte on reads; otherwise drives a sentinel so a stray DUT driver corrupts it.
    assign databus = (iocs === 1'b1 && iorw === 1'b0) ? 8'hzz :
                     ((iocs === 1'b1) ? rx_byte : IDLE_PAT);

    spart_driver #(.CLK_FREQ(50_000_000)) dut (
        .clk       (clk),
        .rst       (rst),
        .br_cfg    (br_cfg),
        .rda       (rda),
        .tbr       (tbr),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .databus   (databus),
        .last_byte (last_byte),
        .echo_cnt  (echo_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic monitor();
        txn_t obs;
        forever begin
            @(negedge clk);
            if (iocs === 1'b1) begin
                obs = {iorw, ioaddr, (iorw === 1'b1) ? 8'h00 : databus};
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0)
                    else begin
                        errors++;
                        $error("FAIL bus_unexpected: observed access 0x%0h expected none", obs);
                    end
                end else begin
                    check("bus_txn", obs, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic push_init(input logic [7:0] lo, input logic [7:0] hi);
        exp_q.push_back({1'b0, 2'b10, lo});
        exp_q.push_back({1'b0, 2'b11, hi});
    endtask

    // One echo starting with the FSM in POLL_RX; optionally stalls tbr, changes br_cfg, or resets mid-write.
    task automatic echo(input logic [7:0] b, input int unsigned tbr_hold,
                        input logic change_cfg, input logic [1:0] new_cfg,
                        input logic [7:0] new_lo, input logic [7:0] new_hi,
                        input logic abort);
        int unsigned n, rd_at, wr_at, tbr_at;
        logic        seen_rd, seen_wr;
        rx_byte = b;
        exp_q.push_back({1'b1, 2'b00, 8'h00});
        exp_q.push_back({1'b0, 2'b00, b});
        tbr = (tbr_hold == 0);
        rda = 1'b1;
        n = 0; rd_at = 0; wr_at = 0; tbr_at = 0;
        seen_rd = 1'b0; seen_wr = 1'b0;
        while (!seen_wr && n < 60) begin
            cyc();
            n++;
            if (iocs === 1'b1 && iorw === 1'b1 && !seen_rd) begin
                seen_rd = 1'b1;
                rd_at   = n;
                rda     = 1'b0;
            end else if (iocs === 1'b1 && iorw === 1'b0) begin
                seen_wr = 1'b1;
                wr_at   = n;
            end else if (seen_rd && !tbr) begin
                check("tbr_wait_iocs", iocs, 1'b0);
                check("tbr_wait_bus_z", databus, IDLE_PAT);
                if (change_cfg && n == rd_at + 1) begin
                    br_cfg = new_cfg;
                    push_init(new_lo, new_hi);
                end
                if (n >= rd_at + tbr_hold) begin
                    tbr    = 1'b1;
                    tbr_at = n;
                end
            end
        end
        check("echo_write_seen", seen_wr, 1'b1);
        check("read_latency", rd_at, 2);
        check("write_latency", wr_at, (tbr_hold == 0) ? 4 : tbr_at + 2);
        if (abort) begin
            #2 rst = 1'b0;
            #1;
            exp_cnt = 16'h0000;
            check("abort_iocs", iocs, 1'b0);
            check("abort_bus_z", databus, IDLE_PAT);
            check("abort_echo_cnt", echo_cnt, exp_cnt);
        end else begin
            exp_cnt++;
            check("echo_wdata", databus, b);
            check("echo_last_byte", last_byte, b);
            check("echo_cnt", echo_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst     = 1'b0;
        rda     = 1'b0;
        tbr     = 1'b1;
        br_cfg  = 2'b01;
        rx_byte = 8'h00;
        exp_cnt = 16'h0000;
        fork
            monitor();
        join_none

        repeat (3) cyc();
        check("rst_iocs", iocs, 1'b0);
        check("rst_iorw", iorw, 1'b1);
        check("rst_ioaddr", ioaddr, 2'b00);
        check("rst_bus_z", databus, IDLE_PAT);
        check("rst_last_byte", last_byte, 8'h00);
        check("rst_echo_cnt", echo_cnt, 16'h0000);

        // 9600 baud -> 325 = 0x0145
        push_init(8'h45, 8'h01);
        rst = 1'b1;
        cyc();
        check("init_c1_iocs", iocs, 1'b1);
        check("init_c1_addr", ioaddr, 2'b10);
        cyc();
        check("init_c2_iocs", iocs, 1'b1);
        check("init_c2_addr", ioaddr, 2'b11);
        cyc();
        check("init_c3_iocs", iocs, 1'b0);
        check("init_c3_iorw", iorw, 1'b1);
        check("init_c3_addr", ioaddr, 2'b00);

        echo(8'h5A, 0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (3) cyc();
        echo(8'h5A, 20, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        repeat (3) cyc();
        // 38400 baud -> 81 = 0x0051, queued behind the echo's write
        echo(8'h3C, 4, 1'b1, 2'b11, 8'h51, 8'h00, 1'b0);
        repeat (8) cyc();
        check("reprog_done", exp_q.size(), 0);
        check("reprog_idle_iocs", iocs, 1'b0);

        echo(8'hA7, 0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        cyc();
        check("abort_hold_last_byte", last_byte, 8'h00);
        check("abort_hold_echo_cnt", echo_cnt, 16'h0000);
        push_init(8'h51, 8'h00);
        rst = 1'b1;
        cyc();
        check("reinit_c1_iocs", iocs, 1'b1);
        check("reinit_c1_addr", ioaddr, 2'b10);
        cyc();
        cyc();
        check("reinit_c3_iocs", iocs, 1'b0);

        cyc();
        force dut.echo_cnt_q = 16'hFFFF;
        cyc();
        release dut.echo_cnt_q;
        cyc();
        exp_cnt = 16'hFFFF;
        check("preload_echo_cnt", echo_cnt, exp_cnt);
        echo(8'h96, 0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        check("wrap_echo_cnt", echo_cnt, 16'h0000);

        repeat (4) cyc();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spart_driver.md
# spart_driver

Bus-master stage sitting directly upstream of the SPART on the processor-side I/O bus. After reset it programs the SPART baud divisor from the board configuration switches. It then runs an echo loop: wait for a received byte, read it, wait for the transmitter to be ready, and write the byte back. It stands in for a processor during minilab bring-up, and it is the only agent driving iocs/iorw/ioaddr and the write side of databus.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to compute the divisors.
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  reset, asynchronous, active-low: asserted when 0, released synchronously to clk.
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400.
- rda  input  1  SPART receive data available.
- tbr  input  1  SPART transmit buffer ready.
- iocs  output  1  chip select, 1 = access this cycle.
- iorw  output  1  1 = read, 0 = write.
- ioaddr  output  2  00 = rx/tx buffer, 01 = status, 10 = divisor low byte, 11 = divisor high byte.
- databus  inout  8  driven only while iocs=1 and iorw=0; high-Z otherwise.
- last_byte  output  8  most recently received byte.
- echo_cnt  output  16  count of completed echoes; wraps modulo 2^16.

## Operation
- Divisor = floor(CLK_FREQ / (16 × baud)), 16 bits. At 50 MHz: 651 (0x028B), 325 (0x0145), 162 (0x00A2), 81 (0x0051).
- FSM states:
  - INIT_LO: write divisor[7:0] to addr 10. Next: INIT_HI.
  - INIT_HI: write divisor[15:8] to addr 11. Next: POLL_RX.
  - POLL_RX: iocs=0. Next: READ when rda=1. Otherwise, next is INIT_LO if a config change is pending, else stay.
  - READ: read addr 00; capture databus into the last_byte register on this clock edge. Next: POLL_TX.
  - POLL_TX: iocs=0. Next: WRITE when tbr=1, else stay.
  - WRITE: write last_byte to addr 00; increment echo_cnt. Next: GAP.
  - GAP: iocs=0 for one cycle, so the SPART can drop rda and tbr. Next: POLL_RX.
- Each bus access lasts exactly one cycle: iocs=1 with iorw, ioaddr and (for writes) databus stable for the whole cycle.
- br_cfg is registered every cycle. A value that differs from the divisor last programmed sets a pending flag. The flag is acted on only in POLL_RX, so an echo in progress always completes first. The flag clears on entry to INIT_LO.
- rda and tbr come from the same clock domain and are used without synchronisers.
- Outside access cycles: iocs=0, iorw=1, ioaddr=00.

## Timing
- Reset values: iocs=0, iorw=1, ioaddr=00, databus=Z, last_byte=0x00, echo_cnt=0, state=INIT_LO, pending=0.
- Reset asserted in the middle of an access: iocs and databus release asynchronously, with no glitch onto databus.
- After reset release, the first rising edge enters INIT_LO. iocs is high for cycles 1–2; POLL_RX is reached at cycle 3.
- Echo latency with rda and tbr already high: POLL_RX→READ→POLL_TX→WRITE = 3 cycles from rda being sampled high to the write cycle.
- Steady-state minimum spacing between echoes is 5 cycles. rda is ignored outside POLL_RX.
- If rda and a pending config change occur together in POLL_RX, READ wins; the reprogram happens on the next visit to POLL_RX.
- echo_cnt increments when WRITE is left: 0xFFFF→0x0000.

## Structure
- Shared package spart_pkg holds:
  - the ioaddr constants (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH);
  - the FSM state enum;
  - a function baud_div(clk_freq, br_cfg) returning 16 bits.
- One natural sub-module: spart_bus_if, which owns the tri-state databus driver and the read-capture register. The FSM stays in spart_driver.

## Test plan
- Reset release with br_cfg=01 → addr 10 is written with 0x45, then addr 11 with 0x01, on consecutive cycles; iocs falls in cycle 3.
- Bus model raises rda with rx byte 0x5A, tbr=1 → one read of addr 00, then a write of 0x5A to addr 00 three cycles after rda is sampled; last_byte=0x5A, echo_cnt=1.
- rda=1 while tbr is held 0 for 20 cycles → the FSM stays in POLL_TX and databus stays Z; the write of 0x5A follows one cycle after tbr rises.
- br_cfg changes 01→11 during POLL_TX → the echo completes first, then 0x51 is written to addr 10 and 0x00 to addr 11.
- rst is pulled low in the middle of the WRITE cycle → iocs=0 and databus=Z immediately; after release, INIT_LO is re-entered and echo_cnt=0.
- echo_cnt preloaded to 0xFFFF by force, then one echo → echo_cnt=0x0000.
